// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between instruction fetch
// and data memory, with data side priority and a pipeline stall output.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   if_req, if_addr                fetch read request and byte address
//   if_rdata, if_ready             fetch read data and completion strobe
//   dm_req, dm_we, dm_addr,        data request, write enable, address,
//   dm_wdata                       write data
//   dm_rdata, dm_ready             data read data and completion strobe
//   mem_req, mem_we, mem_addr,     registered request to backing memory
//   mem_wdata
//   mem_rdata, mem_ack             backing-memory return data and completion
//   pipe_stall                     hold PC, IFID and later stages this cycle
//
// Build option
//   MEM_ARB_STARVE_GUARD_EN  when defined, a fetch waiting behind STARVE_LIMIT
//                            consecutive data grants is granted next. When
//                            undefined, data always wins and STARVE_LIMIT is
//                            not used.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        pipe_stall
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;

    logic [1:0] state;
    logic       isIdle;
    logic       busyIf;
    logic       busyDm;
    logic       forceIf;
    logic       grantIf;
    logic       grantDm;

    assign isIdle = (state == IDLE);
    assign busyIf = (state == BUSY_IF);
    assign busyDm = (state == BUSY_DM);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Consecutive data grants handed out while a fetch was waiting.
    logic [CNT_W-1:0] starveCnt;

    assign forceIf = if_req & dm_req & (starveCnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (grantIf) begin
            starveCnt <= '0;
        end else if (grantDm) begin
            if (!if_req) begin
                starveCnt <= '0;
            end else if (starveCnt != CNT_MAX) begin
                starveCnt <= starveCnt + CNT_W'(1);
            end
        end
    end
`else
    assign forceIf = 1'b0;
`endif

    // Grant decode, only meaningful in IDLE; mem_ack is irrelevant here.
    always_comb begin
        grantIf = 1'b0;
        grantDm = 1'b0;
        if (isIdle) begin
            priority case (1'b1)
                forceIf: grantIf = 1'b1;
                dm_req:  grantDm = 1'b1;
                if_req:  grantIf = 1'b1;
                default: ;
            endcase
        end
    end

    // Memory-side request is registered at grant and held until ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantDm) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grantIf) begin
                        state     <= BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion is combinational in the ack cycle; the FSM only sits in a
    // BUSY state once granted, so a dropped req still gets its pulse.
    assign if_ready = busyIf & mem_ack;
    assign dm_ready = busyDm & mem_ack;

    assign if_rdata = if_ready ? mem_rdata : '0;
    assign dm_rdata = dm_ready ? mem_rdata : '0;

    assign pipe_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter.
// Built with STARVE_LIMIT=2; guard expectations follow the macro setting.
module tb_mem_port_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        pipe_stall;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Leaves the caller at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset = 1'b1;
            if_req = 1'b1; if_addr = $urandom;
            dm_req = 1'b1; dm_we = 1'b1;
            dm_addr = $urandom; dm_wdata = $urandom;
            mem_ack = 1'b1; mem_rdata = $urandom;
            #1;
            checks++;
            if (mem_req !== 1'b0 || mem_we !== 1'b0 ||
                mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_mem got req=%b we=%b a=%h d=%h exp 0",
                         mem_req, mem_we, mem_addr, mem_wdata);
            end
            checks++;
            if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready got if=%b dm=%b exp 0 0",
                         if_ready, dm_ready);
            end
            checks++;
            if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_rdata got if=%h dm=%h exp 0 0",
                         if_rdata, dm_rdata);
            end
            checks++;
            if (pipe_stall !== 1'b1) begin
                failures++;
                $display("FAIL reset_stall got %b exp 1", pipe_stall);
            end
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++;
        if (mem_req !== 1'b0 || if_ready !== 1'b0 || pipe_stall !== 1'b1) begin
            failures++;
            $display("FAIL fetch_req got mreq=%b rdy=%b stall=%b exp 0 0 1",
                     mem_req, if_ready, pipe_stall);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h8C010004;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 ||
            mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_mem got req=%b a=%h we=%b d=%h exp 1 10 0 0",
                     mem_req, mem_addr, mem_we, mem_wdata);
        end
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C010004 ||
            dm_ready !== 1'b0 || pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ready got rdy=%b d=%h dm=%b st=%b exp 1 8c010004 0 0",
                     if_ready, if_rdata, dm_ready, pipe_stall);
        end
        @(negedge clk);
        if_req = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || if_ready !== 1'b0 || if_rdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_done got mreq=%b rdy=%b d=%h exp 0 0 0",
                     mem_req, if_ready, if_rdata);
        end
    endtask

    task automatic test_collision();
        do_reset();
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'hC; dm_wdata = 32'd99;
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            failures++;
            $display("FAIL coll_stall0 got %b exp 1", pipe_stall);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = '0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 32'hC || mem_wdata !== 32'd99) begin
            failures++;
            $display("FAIL coll_dm got req=%b we=%b a=%h d=%0d exp 1 1 c 99",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (dm_ready !== 1'b1 || if_ready !== 1'b0 || pipe_stall !== 1'b1) begin
            failures++;
            $display("FAIL coll_dm_rdy got dm=%b if=%b st=%b exp 1 0 1",
                     dm_ready, if_ready, pipe_stall);
        end
        @(negedge clk);
        dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pipe_stall !== 1'b1) begin
            failures++;
            $display("FAIL coll_gap got mreq=%b st=%b exp 0 1",
                     mem_req, pipe_stall);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20 ||
            mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL coll_if got req=%b a=%h we=%b d=%h exp 1 20 0 0",
                     mem_req, mem_addr, mem_we, mem_wdata);
        end
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h1234 || pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL coll_if_rdy got rdy=%b d=%h st=%b exp 1 1234 0",
                     if_ready, if_rdata, pipe_stall);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_slow_memory();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3);
            mem_rdata = (k == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL slow_hold k=%0d got req=%b a=%h we=%b exp 1 40 0",
                         k, mem_req, mem_addr, mem_we);
            end
            checks++;
            if (dm_ready !== (k == 3) || pipe_stall !== (k != 3)) begin
                failures++;
                $display("FAIL slow_rdy k=%0d got rdy=%b st=%b exp %b %b",
                         k, dm_ready, pipe_stall, k == 3, k != 3);
            end
            @(negedge clk);
        end
        checks++;
        if (dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL slow_rdata_idle got %h exp 0", dm_rdata);
        end
        dm_req = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (dm_ready !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL slow_done got rdy=%b mreq=%b exp 0 0",
                     dm_ready, mem_req);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            failures++;
            $display("FAIL rmid_busy got req=%b a=%h exp 1 80", mem_req, mem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got req=%b a=%h rdy=%b exp 0 0 0",
                     mem_req, mem_addr, if_ready);
        end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE;
        #1;
        checks++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rmid_late_ack got rdy=%b d=%h mreq=%b exp 0 0 0",
                     if_ready, if_rdata, mem_req);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || if_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_idle got mreq=%b rdy=%b exp 0 0",
                     mem_req, if_ready);
        end
    endtask

    task automatic test_guard();
        int order[$];
        int expOrder[6];
        int cyc = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        expOrder = '{1, 1, 0, 1, 1, 0};
`else
        expOrder = '{1, 1, 1, 1, 1, 1};
`endif
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hD0;
        while (order.size() < 6 && cyc < 60) begin
            #1;
            mem_ack = mem_req;
            mem_rdata = $urandom;
            #1;
            if (dm_ready) order.push_back(1);
            if (if_ready) order.push_back(0);
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        checks++;
        if (order.size() != 6) begin
            failures++;
            $display("FAIL guard_count got %0d grants exp 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != expOrder[i]) begin
                failures++;
                $display("FAIL guard_order idx=%0d got dm=%0d exp dm=%0d",
                         i, order[i], expOrder[i]);
            end
        end
    endtask

    // Requesters launch at random and hold until served; memory acks after
    // a random delay and occasionally acks spuriously while nothing is owed.
    task automatic test_random();
        bit ifPend = 0, dmPend = 0, busy = 0, ownerDm = 0, ack, dmW = 0, expW = 0;
        bit ifRdyExp, dmRdyExp, stallExp, pickIf;
        logic [31:0] ifA = '0, dmA = '0, dmD = '0, rd, expA = '0, expD = '0;
        int waitLeft = 0, starve = 0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!ifPend && $urandom_range(0, 1) == 1) begin
                ifPend = 1; ifA = $urandom;
            end
            if (!dmPend && $urandom_range(0, 1) == 1) begin
                dmPend = 1; dmA = $urandom; dmD = $urandom;
                dmW = $urandom_range(0, 1) == 1;
            end
            if_req = ifPend; if_addr = ifA;
            dm_req = dmPend; dm_addr = dmA; dm_wdata = dmD; dm_we = dmW;
            ack = busy ? (waitLeft == 0) : ($urandom_range(0, 3) == 0);
            rd = $urandom;
            mem_ack = ack; mem_rdata = rd;
            ifRdyExp = busy && !ownerDm && ack;
            dmRdyExp = busy && ownerDm && ack;
            stallExp = (ifPend && !ifRdyExp) || (dmPend && !dmRdyExp);
            #1;
            checks++;
            if (mem_req !== busy) begin
                failures++;
                $display("FAIL rnd_mem_req cyc=%0d got %b exp %b", cyc, mem_req, busy);
            end
            if (busy) begin
                checks++;
                if (mem_addr !== expA || mem_we !== expW || mem_wdata !== expD) begin
                    failures++;
                    $display("FAIL rnd_mem_op cyc=%0d got a=%h we=%b d=%h exp a=%h we=%b d=%h",
                             cyc, mem_addr, mem_we, mem_wdata, expA, expW, expD);
                end
            end
            checks++;
            if (if_ready !== ifRdyExp || dm_ready !== dmRdyExp) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got if=%b dm=%b exp if=%b dm=%b",
                         cyc, if_ready, dm_ready, ifRdyExp, dmRdyExp);
            end
            checks++;
            if (if_rdata !== (ifRdyExp ? rd : 32'h0)) begin
                failures++;
                $display("FAIL rnd_if_rdata cyc=%0d got %h exp %h",
                         cyc, if_rdata, ifRdyExp ? rd : 32'h0);
            end
            if (!(dmRdyExp && expW)) begin
                checks++;
                if (dm_rdata !== (dmRdyExp ? rd : 32'h0)) begin
                    failures++;
                    $display("FAIL rnd_dm_rdata cyc=%0d got %h exp %h",
                             cyc, dm_rdata, dmRdyExp ? rd : 32'h0);
                end
            end
            checks++;
            if (pipe_stall !== stallExp) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d got %b exp %b", cyc, pipe_stall, stallExp);
            end
            if (busy) begin
                if (ack) begin
                    busy = 0;
                    if (ownerDm) dmPend = 0;
                    else ifPend = 0;
                end else begin
                    waitLeft--;
                end
            end else if (ifPend || dmPend) begin
                pickIf = !dmPend;
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (ifPend && dmPend && starve == LIMIT) pickIf = 1;
`endif
                busy = 1;
                ownerDm = !pickIf;
                waitLeft = $urandom_range(0, 3);
                expA = pickIf ? ifA : dmA;
                expW = pickIf ? 1'b0 : dmW;
                expD = pickIf ? 32'h0 : dmD;
                if (pickIf || !ifPend) starve = 0;
                else if (starve < LIMIT) starve++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_slow_memory();
        test_reset_mid();
        test_guard();
        test_random();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
